elgamal_encrypt_sequencer: RTL and testbench
============================================

Name: elgamal_encrypt_sequencer

Overview:
Sequences one ElGamal encryption over a single shared modular-exponentiation engine and a modular-multiplication engine. It computes c1 = g^k mod p, then s = y^k mod p, then c2 = m*s mod p. It sits between the host-side AXI-stream request/response channel and the two arithmetic cores, and owns all operand handshakes to them.

Parameters:
SIZE, 64, operand/result width in bits for all data buses.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req_tdata  in  5*SIZE  packed {m, k, y, g, p}, with p in the LSBs
req_tvalid  in  1  request valid
req_tready  out  1  request ready; high only in IDLE
rsp_tdata  out  2*SIZE  packed {c2, c1}
rsp_tvalid  out  1  response valid
rsp_tready  in  1  response ready
rsp_err  out  1  parameter error flag, qualified by rsp_tvalid
exp_base_tdata / exp_power_tdata / exp_modulus_tdata  out  SIZE each  exponentiation operands
exp_base_tvalid / exp_power_tvalid / exp_modulus_tvalid  out  1 each  per-stream operand valid
exp_base_tready / exp_power_tready / exp_modulus_tready  in  1 each  per-stream operand ready
exp_res_tdata  in  SIZE  exponentiation result
exp_res_tvalid  in  1  result valid
exp_res_tready  out  1  result ready
mul_a_tdata / mul_b_tdata / mul_modulus_tdata  out  SIZE each  multiplier operands
mul_a_tvalid / mul_b_tvalid / mul_modulus_tvalid  out  1 each  per-stream operand valid
mul_a_tready / mul_b_tready / mul_modulus_tready  in  1 each  per-stream operand ready
mul_res_tdata  in  SIZE  multiplication result
mul_res_tvalid  in  1  result valid
mul_res_tready  out  1  result ready
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst low, async):
  - state=IDLE; all tvalid outputs 0; exp_res_tready=mul_res_tready=0.
  - rsp_tdata=0, rsp_err=0, busy=0, req_tready=1 once rst deasserts.
  - Internal operand and result registers are cleared to 0.
- States: IDLE, EXP1_ISSUE, EXP1_WAIT, EXP2_ISSUE, EXP2_WAIT, MUL_ISSUE, MUL_WAIT, DONE.
- IDLE:
  - On req_tvalid & req_tready, latch p, g, y, k, m; go to EXP1_ISSUE next cycle.
- Operand issue rule (all *_ISSUE states):
  - All three tvalids assert on entry. Operand data is stable while the state holds.
  - Each stream's tvalid drops the cycle after its own valid&ready handshake; a per-stream "accepted" flag tracks this.
  - Readies may arrive in any order or together. The state advances to the matching *_WAIT state the cycle after the last stream is accepted.
  - No stream is ever presented twice per operation.
- Operand assignment:
  - EXP1_ISSUE: base=g, power=k, modulus=p.
  - EXP2_ISSUE: base=y, power=k, modulus=p.
  - MUL_ISSUE: a=m, b=s, modulus=p.
- *_WAIT:
  - The matching res_tready is held at 1.
  - On res valid&ready, capture the result (c1, s or c2) and drop ready in the same edge.
  - Transitions: EXP1_WAIT→EXP2_ISSUE, EXP2_WAIT→MUL_ISSUE, MUL_WAIT→DONE.
- Result valid outside WAIT states is ignored. Ready is 0 there, so nothing is captured.
- DONE:
  - rsp_tvalid=1 with rsp_tdata={c2,c1} held stable.
  - On rsp_tready, go to IDLE with rsp_tvalid=0 on the next cycle.
  - Backpressure of any length holds the state.
- Latency: 1 cycle from the request handshake to the first operand valid. Each phase costs 1 cycle plus the handshake cycles plus engine latency. DONE is reached 1 cycle after the c2 capture.
- The exponent k is reused unchanged for both exponentiations. s is never exposed on rsp_tdata.
- Reset mid-operation: all valids and readies drop immediately (async). The system resets the engines concurrently. No partial response is ever emitted.

Optional Feature:
ELGAMAL_PARAM_CHECK_EN
- Defined:
  - In the IDLE request handshake cycle, compute err = (p<2) | (k==0) | (m>=p) | (g>=p) | (y>=p).
  - If err, jump straight to DONE: rsp_err=1, rsp_tdata=0, no engine tvalid ever asserted.
  - Otherwise the normal flow runs with rsp_err=0.
- Undefined: rsp_err is tied to 0 and no comparators are built.

Decomposition:
- Package elgamal_pkg:
  - state enum for the 8 states.
  - SIZE default constant.
  - field offset constants for the req/rsp packing.
- Sub-module op_issue_tracker (one instance per engine): owns the three per-stream valid/accepted flags and emits an all_accepted pulse. The controller FSM stays in the top.

Test Plan:
- Nominal: p=23, g=5, y=8, k=3, m=10, with behavioural engines at 5-cycle latency → rsp_tdata={c2=14, c1=10}, rsp_err=0. Exp operands are seen as (5,3,23), then (8,3,23); mul operands as (10,6,23).
- Staggered readies: base ready at cycle +1, modulus at +2, power at +3 → each tvalid drops after its own handshake. No duplicate transfers; result is still {14,10}.
- Response backpressure: rsp_tready held low for 20 cycles → rsp_tvalid and data stay stable, req_tready=0. Release → IDLE next cycle, then accept a second request back-to-back.
- Spurious result: exp_res_tvalid pulsed during EXP1_ISSUE → not captured. The final c1 is still 10.
- Reset mid-operation: assert rst during EXP2_WAIT → all valids and readies 0 and busy=0 asynchronously. After release, a new request completes correctly.
- With ELGAMAL_PARAM_CHECK_EN: m=23, p=23 → DONE within 2 cycles, rsp_err=1, rsp_tdata=0, zero engine tvalid activity.

Source files
------------

// File: rtl/elgamal_pkg.sv
// Shared types and constants for the ElGamal encryption sequencer:
// controller state encoding, default operand width and request/response field slots.
package elgamal_pkg;

  localparam int SIZE_DEFAULT = 64;

  // Field slots are in units of SIZE bits, counted from the LSB.
  localparam int REQ_P_IDX  = 0;
  localparam int REQ_G_IDX  = 1;
  localparam int REQ_Y_IDX  = 2;
  localparam int REQ_K_IDX  = 3;
  localparam int REQ_M_IDX  = 4;
  localparam int RSP_C1_IDX = 0;
  localparam int RSP_C2_IDX = 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_EXP1_ISSUE = 3'd1,
    ST_EXP1_WAIT  = 3'd2,
    ST_EXP2_ISSUE = 3'd3,
    ST_EXP2_WAIT  = 3'd4,
    ST_MUL_ISSUE  = 3'd5,
    ST_MUL_WAIT   = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

endpackage

// File: rtl/op_issue_tracker.sv
// Presents three operand streams to an arithmetic engine exactly once per operation.
// Each valid drops after its own handshake; o_all_accepted flags the edge on which the last one lands.
module op_issue_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [2:0] i_ready,
  output logic [2:0] o_valid,
  output logic       o_all_accepted
);

  logic [2:0] r_valid;
  logic [2:0] r_accepted;
  logic       r_active;
  logic [2:0] w_handshake;
  logic [2:0] w_accepted_next;

  assign w_handshake     = r_valid & i_ready;
  assign w_accepted_next = r_accepted | w_handshake;
  assign o_all_accepted  = r_active & (&w_accepted_next);
  assign o_valid         = r_valid;

  // Per-stream valid/accepted flags for the operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 3'b000;
      r_accepted <= 3'b000;
      r_active   <= 1'b0;
    end else if (i_start) begin
      r_valid    <= 3'b111;
      r_accepted <= 3'b000;
      r_active   <= 1'b1;
    end else begin
      r_valid    <= r_valid & ~i_ready;
      r_accepted <= w_accepted_next;
      if (o_all_accepted) begin
        r_active <= 1'b0;
      end else begin
        r_active <= r_active;
      end
    end
  end

endmodule

// File: rtl/elgamal_encrypt_sequencer.sv
// Sequences c1 = g^k mod p, s = y^k mod p, c2 = m*s mod p over shared exp/mul engines.
// Optional ELGAMAL_PARAM_CHECK_EN rejects out-of-range requests straight to DONE with rsp_err.
module elgamal_encrypt_sequencer
  import elgamal_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5*SIZE-1:0] req_tdata,
  input  logic              req_tvalid,
  output logic              req_tready,
  output logic [2*SIZE-1:0] rsp_tdata,
  output logic              rsp_tvalid,
  input  logic              rsp_tready,
  output logic              rsp_err,
  output logic [SIZE-1:0]   exp_base_tdata,
  output logic [SIZE-1:0]   exp_power_tdata,
  output logic [SIZE-1:0]   exp_modulus_tdata,
  output logic              exp_base_tvalid,
  output logic              exp_power_tvalid,
  output logic              exp_modulus_tvalid,
  input  logic              exp_base_tready,
  input  logic              exp_power_tready,
  input  logic              exp_modulus_tready,
  input  logic [SIZE-1:0]   exp_res_tdata,
  input  logic              exp_res_tvalid,
  output logic              exp_res_tready,
  output logic [SIZE-1:0]   mul_a_tdata,
  output logic [SIZE-1:0]   mul_b_tdata,
  output logic [SIZE-1:0]   mul_modulus_tdata,
  output logic              mul_a_tvalid,
  output logic              mul_b_tvalid,
  output logic              mul_modulus_tvalid,
  input  logic              mul_a_tready,
  input  logic              mul_b_tready,
  input  logic              mul_modulus_tready,
  input  logic [SIZE-1:0]   mul_res_tdata,
  input  logic              mul_res_tvalid,
  output logic              mul_res_tready,
  output logic              busy
);

  state_t          r_state;
  logic [SIZE-1:0] r_p;
  logic [SIZE-1:0] r_y;
  logic [SIZE-1:0] r_k;
  logic [SIZE-1:0] r_m;
  logic [SIZE-1:0] r_s;
  logic [SIZE-1:0] r_c1;
  logic [SIZE-1:0] r_c2;
  logic [SIZE-1:0] r_exp_base;
  logic            r_req_tready;
  logic            r_busy;
  logic            r_rsp_tvalid;
  logic            r_rsp_err;
  logic            r_exp_res_tready;
  logic            r_mul_res_tready;

  logic [SIZE-1:0] w_req_p;
  logic [SIZE-1:0] w_req_g;
  logic [SIZE-1:0] w_req_y;
  logic [SIZE-1:0] w_req_k;
  logic [SIZE-1:0] w_req_m;
  logic            w_req_hs;
  logic            w_exp_res_hs;
  logic            w_mul_res_hs;
  logic            w_param_err;
  logic            w_exp_start;
  logic            w_mul_start;
  logic [2:0]      w_exp_valid;
  logic [2:0]      w_mul_valid;
  logic            w_exp_all_accepted;
  logic            w_mul_all_accepted;

  assign w_req_p = req_tdata[REQ_P_IDX*SIZE +: SIZE];
  assign w_req_g = req_tdata[REQ_G_IDX*SIZE +: SIZE];
  assign w_req_y = req_tdata[REQ_Y_IDX*SIZE +: SIZE];
  assign w_req_k = req_tdata[REQ_K_IDX*SIZE +: SIZE];
  assign w_req_m = req_tdata[REQ_M_IDX*SIZE +: SIZE];

  assign w_req_hs     = (r_state == ST_IDLE) & req_tvalid & r_req_tready;
  assign w_exp_res_hs = exp_res_tvalid & r_exp_res_tready;
  assign w_mul_res_hs = mul_res_tvalid & r_mul_res_tready;

`ifdef ELGAMAL_PARAM_CHECK_EN
  assign w_param_err = (w_req_p < SIZE'(2)) | (w_req_k == SIZE'(0)) |
                       (w_req_m >= w_req_p) | (w_req_g >= w_req_p) | (w_req_y >= w_req_p);
`else
  assign w_param_err = 1'b0;
`endif

  // A new exponentiation starts on an accepted request or on the c1 capture.
  assign w_exp_start = (w_req_hs & ~w_param_err) | ((r_state == ST_EXP1_WAIT) & w_exp_res_hs);
  assign w_mul_start = (r_state == ST_EXP2_WAIT) & w_exp_res_hs;

  op_issue_tracker u_exp_issue (
    .clk            (clk),
    .rst            (rst),
    .i_start        (w_exp_start),
    .i_ready        ({exp_modulus_tready, exp_power_tready, exp_base_tready}),
    .o_valid        (w_exp_valid),
    .o_all_accepted (w_exp_all_accepted)
  );

  op_issue_tracker u_mul_issue (
    .clk            (clk),
    .rst            (rst),
    .i_start        (w_mul_start),
    .i_ready        ({mul_modulus_tready, mul_b_tready, mul_a_tready}),
    .o_valid        (w_mul_valid),
    .o_all_accepted (w_mul_all_accepted)
  );

  assign exp_base_tvalid    = w_exp_valid[0];
  assign exp_power_tvalid   = w_exp_valid[1];
  assign exp_modulus_tvalid = w_exp_valid[2];
  assign mul_a_tvalid       = w_mul_valid[0];
  assign mul_b_tvalid       = w_mul_valid[1];
  assign mul_modulus_tvalid = w_mul_valid[2];

  assign exp_base_tdata    = r_exp_base;
  assign exp_power_tdata   = r_k;
  assign exp_modulus_tdata = r_p;
  assign mul_a_tdata       = r_m;
  assign mul_b_tdata       = r_s;
  assign mul_modulus_tdata = r_p;

  assign exp_res_tready = r_exp_res_tready;
  assign mul_res_tready = r_mul_res_tready;
  assign req_tready     = r_req_tready;
  assign busy           = r_busy;
  assign rsp_tvalid     = r_rsp_tvalid;
  assign rsp_err        = r_rsp_err;
  assign rsp_tdata[RSP_C1_IDX*SIZE +: SIZE] = r_c1;
  assign rsp_tdata[RSP_C2_IDX*SIZE +: SIZE] = r_c2;

  // Controller FSM with all handshake-facing flags registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_IDLE;
      r_p              <= '0;
      r_y              <= '0;
      r_k              <= '0;
      r_m              <= '0;
      r_s              <= '0;
      r_c1             <= '0;
      r_c2             <= '0;
      r_exp_base       <= '0;
      r_req_tready     <= 1'b1;
      r_busy           <= 1'b0;
      r_rsp_tvalid     <= 1'b0;
      r_rsp_err        <= 1'b0;
      r_exp_res_tready <= 1'b0;
      r_mul_res_tready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_hs) begin
            r_p          <= w_req_p;
            r_y          <= w_req_y;
            r_k          <= w_req_k;
            r_m          <= w_req_m;
            r_exp_base   <= w_req_g;
            r_req_tready <= 1'b0;
            r_busy       <= 1'b1;
            r_rsp_err    <= w_param_err;
            if (w_param_err) begin
              r_c1         <= '0;
              r_c2         <= '0;
              r_rsp_tvalid <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_state <= ST_EXP1_ISSUE;
            end
          end
        end
        ST_EXP1_ISSUE: begin
          if (w_exp_all_accepted) begin
            r_exp_res_tready <= 1'b1;
            r_state          <= ST_EXP1_WAIT;
          end
        end
        ST_EXP1_WAIT: begin
          if (w_exp_res_hs) begin
            r_c1             <= exp_res_tdata;
            r_exp_base       <= r_y;
            r_exp_res_tready <= 1'b0;
            r_state          <= ST_EXP2_ISSUE;
          end
        end
        ST_EXP2_ISSUE: begin
          if (w_exp_all_accepted) begin
            r_exp_res_tready <= 1'b1;
            r_state          <= ST_EXP2_WAIT;
          end
        end
        ST_EXP2_WAIT: begin
          if (w_exp_res_hs) begin
            r_s              <= exp_res_tdata;
            r_exp_res_tready <= 1'b0;
            r_state          <= ST_MUL_ISSUE;
          end
        end
        ST_MUL_ISSUE: begin
          if (w_mul_all_accepted) begin
            r_mul_res_tready <= 1'b1;
            r_state          <= ST_MUL_WAIT;
          end
        end
        ST_MUL_WAIT: begin
          if (w_mul_res_hs) begin
            r_c2             <= mul_res_tdata;
            r_mul_res_tready <= 1'b0;
            r_rsp_tvalid     <= 1'b1;
            r_state          <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_tready) begin
            r_rsp_tvalid <= 1'b0;
            r_req_tready <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_tvalid     <= 1'b0;
          r_exp_res_tready <= 1'b0;
          r_mul_res_tready <= 1'b0;
          r_req_tready     <= 1'b1;
          r_busy           <= 1'b0;
          r_state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elgamal_encrypt_sequencer.sv
// Randomised self-checking bench: behavioural exp/mul engines plus an arithmetic reference model.
// Define ELGAMAL_PARAM_CHECK_EN for both RTL and bench to exercise parameter rejection.
module tb_elgamal_encrypt_sequencer;
  import elgamal_pkg::*;

  localparam int SIZE = 64;
  localparam int LIM  = 2000;
  localparam int STAG [3] = '{1, 3, 2};

  logic clk = 1'b0;
  logic rst;
  logic [5*SIZE-1:0] req_tdata;
  logic req_tvalid, req_tready;
  logic [2*SIZE-1:0] rsp_tdata;
  logic rsp_tvalid, rsp_tready, rsp_err, busy;
  logic [SIZE-1:0] exp_base_tdata, exp_power_tdata, exp_modulus_tdata, exp_res_tdata;
  logic exp_base_tvalid, exp_power_tvalid, exp_modulus_tvalid;
  logic exp_base_tready, exp_power_tready, exp_modulus_tready;
  logic exp_res_tvalid, exp_res_tready;
  logic [SIZE-1:0] mul_a_tdata, mul_b_tdata, mul_modulus_tdata, mul_res_tdata;
  logic mul_a_tvalid, mul_b_tvalid, mul_modulus_tvalid;
  logic mul_a_tready, mul_b_tready, mul_modulus_tready;
  logic mul_res_tvalid, mul_res_tready;

  int n_cmp = 0;
  int n_bad = 0;
  bit stagger = 1'b0;
  int fix_lat = 5;
  bit exp_spur_arm = 1'b0;
  logic exp_spur_rdy = 1'b0;
  int exp_dup = 0, mul_dup = 0, act_cnt = 0;
  bit exp_have [3], mul_have [3];
  logic [63:0] exp_got [3], mul_got [3];
  logic [191:0] exp_ops_q [$];
  logic [191:0] mul_ops_q [$];

  always #5 clk = ~clk;

  elgamal_encrypt_sequencer #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
    .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_err(rsp_err),
    .exp_base_tdata(exp_base_tdata), .exp_power_tdata(exp_power_tdata),
    .exp_modulus_tdata(exp_modulus_tdata),
    .exp_base_tvalid(exp_base_tvalid), .exp_power_tvalid(exp_power_tvalid),
    .exp_modulus_tvalid(exp_modulus_tvalid),
    .exp_base_tready(exp_base_tready), .exp_power_tready(exp_power_tready),
    .exp_modulus_tready(exp_modulus_tready),
    .exp_res_tdata(exp_res_tdata), .exp_res_tvalid(exp_res_tvalid), .exp_res_tready(exp_res_tready),
    .mul_a_tdata(mul_a_tdata), .mul_b_tdata(mul_b_tdata), .mul_modulus_tdata(mul_modulus_tdata),
    .mul_a_tvalid(mul_a_tvalid), .mul_b_tvalid(mul_b_tvalid), .mul_modulus_tvalid(mul_modulus_tvalid),
    .mul_a_tready(mul_a_tready), .mul_b_tready(mul_b_tready), .mul_modulus_tready(mul_modulus_tready),
    .mul_res_tdata(mul_res_tdata), .mul_res_tvalid(mul_res_tvalid), .mul_res_tready(mul_res_tready),
    .busy(busy)
  );

  task automatic check_value(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] m);
    logic [127:0] t;
    t = ({64'd0, a} * {64'd0, b}) % {64'd0, m};
    return t[63:0];
  endfunction

  function automatic logic [63:0] powmod(input logic [63:0] b, input logic [63:0] e,
                                         input logic [63:0] m);
    logic [63:0] r, bb;
    r  = 64'd1 % m;
    bb = b % m;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = mulmod(r, bb, m);
      bb = mulmod(bb, bb, m);
    end
    return r;
  endfunction

  // Behavioural exponentiation engine with random/staggered readies and latency
  initial begin : exp_engine
    logic [2:0] v, rdy;
    logic [63:0] d [3];
    int wt [3], dly [3];
    logic [63:0] res;
    int lat;
    bit hs_pend, spur_on;
    lat = 0; hs_pend = 1'b0; spur_on = 1'b0; res = 64'd0;
    for (int i = 0; i < 3; i++) begin wt[i] = 0; dly[i] = 0; exp_have[i] = 1'b0; end
    exp_base_tready = 1'b0; exp_power_tready = 1'b0; exp_modulus_tready = 1'b0;
    exp_res_tvalid = 1'b0; exp_res_tdata = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_base_tready = 1'b0; exp_power_tready = 1'b0; exp_modulus_tready = 1'b0;
        exp_res_tvalid = 1'b0; lat = 0; hs_pend = 1'b0; spur_on = 1'b0;
        for (int i = 0; i < 3; i++) begin exp_have[i] = 1'b0; wt[i] = 0; end
      end else begin
        if (hs_pend || spur_on) exp_res_tvalid = 1'b0;
        spur_on = 1'b0;
        v = {exp_modulus_tvalid, exp_power_tvalid, exp_base_tvalid};
        d[0] = exp_base_tdata; d[1] = exp_power_tdata; d[2] = exp_modulus_tdata;
        for (int i = 0; i < 3; i++) begin
          if (v[i]) begin
            if (wt[i] == 0) dly[i] = stagger ? STAG[i] : int'($urandom_range(0, 3));
            rdy[i] = (wt[i] >= dly[i]);
            wt[i]++;
          end else begin
            rdy[i] = 1'b0;
            wt[i] = 0;
          end
        end
        {exp_modulus_tready, exp_power_tready, exp_base_tready} = rdy;
        for (int i = 0; i < 3; i++) begin
          if (v[i] && rdy[i]) begin
            if (exp_have[i]) exp_dup++;
            exp_have[i] = 1'b1;
            exp_got[i] = d[i];
          end
        end
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin exp_res_tvalid = 1'b1; exp_res_tdata = res; end
        end
        if (exp_have[0] && exp_have[1] && exp_have[2]) begin
          exp_ops_q.push_back({exp_got[2], exp_got[1], exp_got[0]});
          res = powmod(exp_got[0], exp_got[1], exp_got[2]);
          lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 8));
          for (int i = 0; i < 3; i++) exp_have[i] = 1'b0;
        end
        if (exp_spur_arm && (v != 3'b000) && exp_ops_q.size() == 0 && lat == 0 && !exp_res_tvalid) begin
          exp_res_tvalid = 1'b1; exp_res_tdata = 64'hBAD;
          spur_on = 1'b1; exp_spur_arm = 1'b0; exp_spur_rdy = exp_res_tready;
        end
        hs_pend = exp_res_tvalid && exp_res_tready && !spur_on;
      end
    end
  end

  // Behavioural modular multiplier
  initial begin : mul_engine
    logic [2:0] v, rdy;
    logic [63:0] d [3];
    int wt [3], dly [3];
    logic [63:0] res;
    int lat;
    bit hs_pend;
    lat = 0; hs_pend = 1'b0; res = 64'd0;
    for (int i = 0; i < 3; i++) begin wt[i] = 0; dly[i] = 0; mul_have[i] = 1'b0; end
    mul_a_tready = 1'b0; mul_b_tready = 1'b0; mul_modulus_tready = 1'b0;
    mul_res_tvalid = 1'b0; mul_res_tdata = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mul_a_tready = 1'b0; mul_b_tready = 1'b0; mul_modulus_tready = 1'b0;
        mul_res_tvalid = 1'b0; lat = 0; hs_pend = 1'b0;
        for (int i = 0; i < 3; i++) begin mul_have[i] = 1'b0; wt[i] = 0; end
      end else begin
        if (hs_pend) mul_res_tvalid = 1'b0;
        v = {mul_modulus_tvalid, mul_b_tvalid, mul_a_tvalid};
        d[0] = mul_a_tdata; d[1] = mul_b_tdata; d[2] = mul_modulus_tdata;
        for (int i = 0; i < 3; i++) begin
          if (v[i]) begin
            if (wt[i] == 0) dly[i] = stagger ? STAG[i] : int'($urandom_range(0, 3));
            rdy[i] = (wt[i] >= dly[i]);
            wt[i]++;
          end else begin
            rdy[i] = 1'b0;
            wt[i] = 0;
          end
        end
        {mul_modulus_tready, mul_b_tready, mul_a_tready} = rdy;
        for (int i = 0; i < 3; i++) begin
          if (v[i] && rdy[i]) begin
            if (mul_have[i]) mul_dup++;
            mul_have[i] = 1'b1;
            mul_got[i] = d[i];
          end
        end
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin mul_res_tvalid = 1'b1; mul_res_tdata = res; end
        end
        if (mul_have[0] && mul_have[1] && mul_have[2]) begin
          mul_ops_q.push_back({mul_got[2], mul_got[1], mul_got[0]});
          res = mulmod(mul_got[0], mul_got[1], mul_got[2]);
          lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 8));
          for (int i = 0; i < 3; i++) mul_have[i] = 1'b0;
        end
        hs_pend = mul_res_tvalid && mul_res_tready;
      end
    end
  end

  // Counts cycles with any engine operand valid raised
  always @(negedge clk) begin
    if (rst && (exp_base_tvalid || exp_power_tvalid || exp_modulus_tvalid ||
                mul_a_tvalid || mul_b_tvalid || mul_modulus_tvalid)) act_cnt++;
  end

  task automatic send_req(input logic [63:0] p, g, y, k, m);
    int t;
    req_tdata  = {m, k, y, g, p};
    req_tvalid = 1'b1;
    t = 0;
    while (!req_tready && t < LIM) begin @(negedge clk); t++; end
    @(negedge clk);
    req_tvalid = 1'b0;
    check_value("req_handshake", t < LIM, 1'b1);
  endtask

  task automatic run_txn(input logic [63:0] p, g, y, k, m, input int bp);
    logic [63:0] c1, s, c2;
    int t;
    c1 = powmod(g, k, p);
    s  = powmod(y, k, p);
    c2 = mulmod(m, s, p);
    exp_ops_q.delete(); mul_ops_q.delete();
    exp_dup = 0; mul_dup = 0;
    rsp_tready = 1'b0;
    send_req(p, g, y, k, m);
    t = 0;
    while (!rsp_tvalid && t < LIM) begin @(negedge clk); t++; end
    check_value("rsp_arrived", t < LIM, 1'b1);
    check_value("rsp_data", rsp_tdata, {c2, c1});
    check_value("rsp_err", rsp_err, 1'b0);
    check_value("done_flags", {busy, req_tready}, 2'b10);
    check_value("exp_op_count", exp_ops_q.size(), 2);
    if (exp_ops_q.size() >= 1) check_value("exp_ops1", exp_ops_q[0], {p, k, g});
    if (exp_ops_q.size() >= 2) check_value("exp_ops2", exp_ops_q[1], {p, k, y});
    check_value("mul_op_count", mul_ops_q.size(), 1);
    if (mul_ops_q.size() >= 1) check_value("mul_ops", mul_ops_q[0], {p, s, m});
    check_value("dup_transfers", exp_dup + mul_dup, 0);
    if (bp > 0) begin
      repeat (bp) @(negedge clk);
      check_value("bp_hold", {rsp_tvalid, req_tready, busy, rsp_tdata}, {3'b101, c2, c1});
    end
    rsp_tready = 1'b1;
    @(negedge clk);
    rsp_tready = 1'b0;
    check_value("back_to_idle", {rsp_tvalid, req_tready, busy}, 3'b010);
  endtask

  initial begin
    logic [63:0] p, g, y, k, m;
    int t;
    rst = 1'b0; req_tvalid = 1'b0; req_tdata = '0; rsp_tready = 1'b0;
    repeat (3) @(negedge clk);
    check_value("reset_ctrl", {exp_base_tvalid, exp_power_tvalid, exp_modulus_tvalid,
                mul_a_tvalid, mul_b_tvalid, mul_modulus_tvalid, exp_res_tready,
                mul_res_tready, rsp_tvalid, rsp_err, busy}, 11'd0);
    check_value("reset_data", rsp_tdata, 128'd0);
    rst = 1'b1;
    @(negedge clk);
    check_value("post_reset", {req_tready, busy}, 2'b10);

    fix_lat = 5;
    run_txn(64'd23, 64'd5, 64'd8, 64'd3, 64'd10, 0);
    stagger = 1'b1;
    run_txn(64'd23, 64'd5, 64'd8, 64'd3, 64'd10, 0);
    stagger = 1'b0;
    run_txn(64'd23, 64'd5, 64'd8, 64'd3, 64'd10, 20);
    run_txn(64'd97, 64'd5, 64'd33, 64'd7, 64'd50, 0);

    exp_spur_arm = 1'b1;
    run_txn(64'd23, 64'd5, 64'd8, 64'd3, 64'd10, 0);
    check_value("spur_fired", exp_spur_arm, 1'b0);
    check_value("spur_ready", exp_spur_rdy, 1'b0);

    exp_ops_q.delete();
    send_req(64'd23, 64'd5, 64'd8, 64'd3, 64'd10);
    t = 0;
    while (!(exp_ops_q.size() == 2 && exp_res_tready) && t < LIM) begin @(negedge clk); t++; end
    check_value("reach_exp2_wait", t < LIM, 1'b1);
    rst = 1'b0;
    #1;
    check_value("midop_reset", {exp_base_tvalid, exp_power_tvalid, exp_modulus_tvalid,
                mul_a_tvalid, mul_b_tvalid, mul_modulus_tvalid, exp_res_tready,
                mul_res_tready, rsp_tvalid, busy}, 10'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_txn(64'd23, 64'd5, 64'd8, 64'd3, 64'd10, 0);

`ifdef ELGAMAL_PARAM_CHECK_EN
    act_cnt = 0;
    send_req(64'd23, 64'd5, 64'd8, 64'd3, 64'd23);
    t = 0;
    while (!rsp_tvalid && t < 2) begin @(negedge clk); t++; end
    check_value("perr_done", rsp_tvalid, 1'b1);
    check_value("perr_rsp", {rsp_err, rsp_tdata}, {1'b1, 128'd0});
    check_value("perr_no_engine", act_cnt, 0);
    rsp_tready = 1'b1;
    @(negedge clk);
    rsp_tready = 1'b0;
    check_value("perr_idle", {rsp_tvalid, req_tready}, 2'b01);
`endif

    fix_lat = 0;
    for (int n = 0; n < 8; n++) begin
      p = {$urandom, $urandom} | 64'd3;
      g = {$urandom, $urandom} % p;
      y = {$urandom, $urandom} % p;
      m = {$urandom, $urandom} % p;
      k = {$urandom, $urandom} | 64'd1;
      run_txn(p, g, y, k, m, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
